fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
Parametrised synchronous FIFO. It is the buffered successor to the single-read-port RAM and the up-counter blocks. It stores DATA_WIDTH-bit words in a 2^ADDR_WIDTH-deep array with read and write pointers, an occupancy counter, threshold flags and sticky error flags. It sits between a producer and a consumer in the same clock domain, for example as a datapath operand queue or an instruction prefetch buffer.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, pointer width; DEPTH = 2^ADDR_WIDTH words
ALMOST_FULL_LEVEL, DEPTH-2, oAlmostFull asserts when count >= this value
ALMOST_EMPTY_LEVEL, 2, oAlmostEmpty asserts when count <= this value

Ports:
Clock  in  1  single clock; all logic on the rising edge
Reset  in  1  asynchronous, active-low reset
iWriteEnable  in  1  write request
iDataIn  in  DATA_WIDTH  write data
iReadEnable  in  1  read request
iClearErrors  in  1  synchronous clear of the sticky error flags
oDataOut  out  DATA_WIDTH  registered read data
oDataValid  out  1  oDataOut holds a newly popped word this cycle
oFull  out  1  count == DEPTH
oEmpty  out  1  count == 0
oAlmostFull  out  1  count >= ALMOST_FULL_LEVEL
oAlmostEmpty  out  1  count <= ALMOST_EMPTY_LEVEL
oCount  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
oOverflow  out  1  sticky: a write was attempted while full and was rejected
oUnderflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset low (asynchronous):
  - Pointers = 0; oCount = 0; oEmpty = 1; oFull = 0.
  - oAlmostEmpty = 1; oAlmostFull = 0.
  - oDataOut = 0; oDataValid = 0; oOverflow = 0; oUnderflow = 0.
  - Array contents are not cleared.
- Reset asserted mid-operation discards all stored words immediately. The first cycle after release behaves as an empty FIFO.
- Acceptance rules, evaluated on the rising edge:
  - wr_ok = iWriteEnable & (~oFull | rd_ok).
  - rd_ok = iReadEnable & ~oEmpty.
- Full and simultaneous read+write: both are accepted and the count is unchanged.
- Empty and simultaneous read+write: the write is accepted and the read is rejected; there is no bypass. oUnderflow is set and the count becomes 1.
- Write: Ram[wptr] <= iDataIn; wptr increments modulo DEPTH and wraps naturally.
- Read:
  - oDataOut <= Ram[rptr]; rptr increments modulo DEPTH.
  - oDataValid = 1 on the following cycle, so latency is 1 clock from accepted iReadEnable to data.
  - When no read is accepted, oDataValid = 0 and oDataOut holds its last value.
- Count: oCount <= oCount + wr_ok - rd_ok. All flags are registered and derived from the next count, so they are valid in the same cycle as oCount.
- Rejected write:
  - Happens when iWriteEnable & oFull & ~rd_ok.
  - Data is dropped, oOverflow <= 1, and pointers and count are unchanged.
- Rejected read:
  - Happens when iReadEnable & oEmpty.
  - oUnderflow <= 1; oDataValid = 0 next cycle; oDataOut is unchanged.
- Error flags:
  - Both stay set until iClearErrors = 1 on a clock edge.
  - If a new error and iClearErrors occur in the same cycle, the flag stays set (the error wins).
- No combinational path from inputs to outputs.

Decomposition:
- Shared constants file: the DEPTH derivation (1 << ADDR_WIDTH) and the default threshold localparams, reused by other queue blocks.
- One natural sub-module: fifo_ram, a simple dual-port array with a registered read (write port and read port, no bypass). The parent owns pointers, count, flags and errors.
- Pointer increment reuses the existing up-counter style, but with the asynchronous active-low reset.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1):
1. Reset sequence: after release -> oEmpty=1, oAlmostEmpty=1, oCount=0, oDataValid=0, oOverflow=0, oUnderflow=0.
2. Write 0x11,0x22,0x33,0x44 on consecutive cycles:
   - oCount goes 1,2,3,4.
   - oAlmostEmpty drops when oCount reaches 2; oAlmostFull rises at 3; oFull rises at 4.
   - A fifth write of 0x55 is rejected: oOverflow=1, oCount stays 4.
3. Full FIFO, simultaneous write 0x66 and read:
   - oDataOut=0x11 with oDataValid=1 next cycle; oCount stays 4.
   - Subsequent reads return 0x22,0x33,0x44,0x66.
4. Wrap-around: 10 interleaved write/read pairs with data 0xA0..0xA9 -> reads return 0xA0..0xA9 in order; oCount never exceeds 1; pointers wrap twice.
5. Empty FIFO, simultaneous read and write 0x77:
   - oUnderflow=1, oDataValid=0, oCount=1.
   - Next read returns 0x77.
   - iClearErrors=1 clears oUnderflow and oOverflow the following cycle.
6. Reset low while oCount=3 and a read is pending: oCount=0, oEmpty=1 and oDataValid=0 immediately (asynchronous), with no read data emitted after release.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared queue constants: depth derivation, default thresholds and the flag bundle.
package fifo_sync_pkg;

    localparam int unsigned FIFO_DEF_DATA_WIDTH   = 8;
    localparam int unsigned FIFO_DEF_ADDR_WIDTH   = 4;
    localparam int unsigned FIFO_DEF_ALMOST_EMPTY = 2;
    localparam int unsigned FIFO_DEF_AF_MARGIN    = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

    function automatic int unsigned fifo_almost_full_default(input int unsigned addr_width);
        return fifo_depth(addr_width) - FIFO_DEF_AF_MARGIN;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array with a registered read port and no write-to-read bypass.
module fifo_ram
    import fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value when no read is accepted.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO: pointers, occupancy count, registered threshold flags and sticky errors.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = FIFO_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH         = FIFO_DEF_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL_LEVEL  = fifo_almost_full_default(ADDR_WIDTH),
    parameter int unsigned ALMOST_EMPTY_LEVEL = FIFO_DEF_ALMOST_EMPTY
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iWriteEnable,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iReadEnable,
    input  logic                  iClearErrors,
    output logic [DATA_WIDTH-1:0] oDataOut,
    output logic                  oDataValid,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  wr_ok_c;
    logic                  rd_ok_c;
    logic [CNT_W-1:0]      count_next_c;
    fifo_flags_t           flags_next_c;
    logic                  overflow_next_c;
    logic                  underflow_next_c;

    // Acceptance, next occupancy and flags derived from the next count.
    always_comb begin
        rd_ok_c          = iReadEnable & ~oEmpty;
        wr_ok_c          = iWriteEnable & (~oFull | rd_ok_c);
        count_next_c     = oCount + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
        flags_next_c     = '0;
        flags_next_c.full         = (count_next_c == CNT_W'(DEPTH));
        flags_next_c.empty        = (count_next_c == '0);
        flags_next_c.almost_full  = (count_next_c >= CNT_W'(ALMOST_FULL_LEVEL));
        flags_next_c.almost_empty = (count_next_c <= CNT_W'(ALMOST_EMPTY_LEVEL));
        // A fresh error in the same cycle as a clear keeps the flag set.
        overflow_next_c  = (oOverflow & ~iClearErrors) | (iWriteEnable & oFull & ~rd_ok_c);
        underflow_next_c = (oUnderflow & ~iClearErrors) | (iReadEnable & oEmpty);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wptr         <= '0;
            rptr         <= '0;
            oCount       <= '0;
            oFull        <= 1'b0;
            oEmpty       <= 1'b1;
            oAlmostFull  <= 1'b0;
            oAlmostEmpty <= 1'b1;
            oDataValid   <= 1'b0;
            oOverflow    <= 1'b0;
            oUnderflow   <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (rd_ok_c) begin
                rptr <= rptr + ADDR_WIDTH'(1);
            end
            oCount       <= count_next_c;
            oFull        <= flags_next_c.full;
            oEmpty       <= flags_next_c.empty;
            oAlmostFull  <= flags_next_c.almost_full;
            oAlmostEmpty <= flags_next_c.almost_empty;
            oDataValid   <= rd_ok_c;
            oOverflow    <= overflow_next_c;
            oUnderflow   <= underflow_next_c;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (wr_ok_c),
        .wr_addr (wptr),
        .wr_data (iDataIn),
        .rd_en   (rd_ok_c),
        .rd_addr (rptr),
        .rd_data (oDataOut)
    );

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_fifo_sync;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;

    logic          Clock;
    logic          Reset;
    logic          we;
    logic [DW-1:0] din;
    logic          re;
    logic          clr;
    logic [DW-1:0] oDataOut;
    logic          oDataValid;
    logic          oFull;
    logic          oEmpty;
    logic          oAlmostFull;
    logic          oAlmostEmpty;
    logic [AW:0]   oCount;
    logic          oOverflow;
    logic          oUnderflow;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;

    fifo_sync #(
        .DATA_WIDTH         (DW),
        .ADDR_WIDTH         (AW),
        .ALMOST_FULL_LEVEL  (AF),
        .ALMOST_EMPTY_LEVEL (AE)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iWriteEnable (we),
        .iDataIn      (din),
        .iReadEnable  (re),
        .iClearErrors (clr),
        .oDataOut     (oDataOut),
        .oDataValid   (oDataValid),
        .oFull        (oFull),
        .oEmpty       (oEmpty),
        .oAlmostFull  (oAlmostFull),
        .oAlmostEmpty (oAlmostEmpty),
        .oCount       (oCount),
        .oOverflow    (oOverflow),
        .oUnderflow   (oUnderflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus output/error state, updated from the rules directly.
    always @(posedge Clock or negedge Reset) begin : model
        bit full_b;
        bit empty_b;
        bit rd_b;
        bit wr_b;
        if (!Reset) begin
            mq.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            full_b  = (mq.size() == DEPTH);
            empty_b = (mq.size() == 0);
            rd_b    = re && !empty_b;
            wr_b    = we && (!full_b || rd_b);
            m_ovf   = (m_ovf && !clr) || (we && full_b && !rd_b);
            m_unf   = (m_unf && !clr) || (re && empty_b);
            m_valid = rd_b;
            if (rd_b) m_dout = mq.pop_front();
            if (wr_b) mq.push_back(din);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Clock) begin
        if (cmp_en) begin
            int n;
            n = mq.size();
            chk("m_count",   32'(oCount),       32'(n));
            chk("m_empty",   32'(oEmpty),       32'(n == 0));
            chk("m_full",    32'(oFull),        32'(n == DEPTH));
            chk("m_afull",   32'(oAlmostFull),  32'(n >= AF));
            chk("m_aempty",  32'(oAlmostEmpty), 32'(n <= AE));
            chk("m_valid",   32'(oDataValid),   32'(m_valid));
            chk("m_dout",    32'(oDataOut),     32'(m_dout));
            chk("m_ovf",     32'(oOverflow),    32'(m_ovf));
            chk("m_unf",     32'(oUnderflow),   32'(m_unf));
        end
    end

    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        we  = w;
        din = d;
        re  = r;
        clr = c;
        @(negedge Clock);
    endtask

    initial begin
        logic [DW-1:0] wdat [4];
        logic [DW-1:0] rdat [4];
        wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
        rdat = '{8'h22, 8'h33, 8'h44, 8'h66};
        Reset = 1'b0;
        we = 1'b0; re = 1'b0; clr = 1'b0; din = '0;
        repeat (2) @(negedge Clock);
        cmp_en = 1'b1;
        Reset  = 1'b1;
        @(negedge Clock);

        chk("rst_empty",  32'(oEmpty), 1);
        chk("rst_aempty", 32'(oAlmostEmpty), 1);
        chk("rst_count",  32'(oCount), 0);
        chk("rst_valid",  32'(oDataValid), 0);
        chk("rst_ovf",    32'(oOverflow), 0);
        chk("rst_unf",    32'(oUnderflow), 0);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, wdat[i], 1'b0, 1'b0);
            chk("fill_count",  32'(oCount), 32'(i + 1));
            chk("fill_aempty", 32'(oAlmostEmpty), 32'(i == 0));
            chk("fill_afull",  32'(oAlmostFull), 32'(i >= 2));
            chk("fill_full",   32'(oFull), 32'(i == 3));
        end
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_set",   32'(oOverflow), 1);
        chk("ovf_count", 32'(oCount), 4);

        cyc(1'b1, 8'h66, 1'b1, 1'b0);
        chk("fullrw_dout",  32'(oDataOut), 32'h11);
        chk("fullrw_valid", 32'(oDataValid), 1);
        chk("fullrw_count", 32'(oCount), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain_dout",  32'(oDataOut), 32'(rdat[i]));
            chk("drain_valid", 32'(oDataValid), 1);
        end
        chk("drain_count", 32'(oCount), 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("hold_valid", 32'(oDataValid), 0);
        chk("hold_dout",  32'(oDataOut), 32'h66);

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
            chk("wrap_wcount", 32'(oCount), 1);
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_dout",   32'(oDataOut), 32'(8'hA0 + i));
            chk("wrap_valid",  32'(oDataValid), 1);
            chk("wrap_rcount", 32'(oCount), 0);
        end

        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("emptyrw_unf",   32'(oUnderflow), 1);
        chk("emptyrw_valid", 32'(oDataValid), 0);
        chk("emptyrw_count", 32'(oCount), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("emptyrw_dout",  32'(oDataOut), 32'h77);
        chk("emptyrw_rv",    32'(oDataValid), 1);
        chk("ovf_sticky",    32'(oOverflow), 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(oOverflow), 0);
        chk("clr_unf", 32'(oUnderflow), 0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("errwins_unf", 32'(oUnderflow), 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("clr2_unf", 32'(oUnderflow), 0);

        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(oCount), 3);
        chk("pre_rst_valid", 32'(oDataValid), 1);
        re = 1'b1;
        #2 Reset = 1'b0;
        #1;
        chk("arst_count", 32'(oCount), 0);
        chk("arst_empty", 32'(oEmpty), 1);
        chk("arst_valid", 32'(oDataValid), 0);
        chk("arst_dout",  32'(oDataOut), 0);
        @(negedge Clock);
        re    = 1'b0;
        Reset = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(oDataValid), 0);
        chk("post_rst_count", 32'(oCount), 0);

        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 100) < 55, DW'($urandom), ($urandom % 100) < 50,
                ($urandom % 100) < 5);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
